data_sram_arbiter: RTL and testbench
====================================

Name: data_sram_arbiter

Overview:
Shares the single data SRAM port between two requesters: port 0 is the pipeline load/store issued from the execute stage, and port 1 is an auxiliary master (debug/DMA). It arbitrates requests, drives the SRAM enable, byte-write-enable, address and write data, and routes the 1-cycle-latency read data back to the owner. A one-entry response hold register absorbs requester backpressure.

Parameters:
ADDR_W, 32, SRAM address width
DATA_W, 32, SRAM data width; byte-enable width is DATA_W/8
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 wins

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  2  per-port request valid
req_ready  out  2  per-port request accepted this cycle
req_we  in  2x(DATA_W/8)  per-port byte write enables; all-zero means read
req_addr  in  2xADDR_W  per-port address
req_wdata  in  2xDATA_W  per-port write data
resp_valid  out  2  per-port read response valid
resp_ready  in  2  per-port response accept
resp_rdata  out  DATA_W  read data, shared by both ports, qualified by resp_valid
data_sram_en  out  1  SRAM enable
data_sram_wen  out  DATA_W/8  SRAM byte write enables
data_sram_addr  out  ADDR_W  SRAM address
data_sram_wdata  out  DATA_W  SRAM write data
data_sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset: clk and resetn are fixed as above: a single clock, and reset is asynchronous and active-low.
- All state clears immediately when resetn is low: rr_ptr=0, inflight=0, hold_v=0.
- Every output is 0 during reset.
- Per-port transactions complete in order. Writes produce no response.
- A handshake occurs on req_valid[i] && req_ready[i]. At most one grant is made per cycle.
- Grant is combinational in the same cycle. When granted, data_sram_en=1 and wen/addr/wdata come from the winner.
- When no grant is made, data_sram_en=0 and wen=0.
- Arbitration with RR_EN=1:
  - If both ports request and are eligible, the port indicated by rr_ptr wins.
  - After any grant, rr_ptr is set to the other port.
- Arbitration with RR_EN=0: port 0 always wins.
- Read eligibility (read_ok): a read may issue in cycle C only if there is no response slot conflict in C+1. It holds when one of these is true:
  - (a) inflight=0 and hold_v=0
  - (b) inflight=1 and resp_ready[inflight_id]=1 in C
  - (c) hold_v=1 and resp_ready[hold_id]=1 in C, with inflight=0
- Writes are always eligible; they need no response slot.
- An ineligible read does not block a write from the other port.
- Response path:
  - A read issued in cycle N sets inflight=1 and inflight_id=i for cycle N+1.
  - In N+1, resp_valid[i]=1 and resp_rdata=data_sram_rdata (bypass).
  - If resp_ready[i]=0 in N+1, the data is captured: hold_v=1, hold_id=i, hold_data=rdata.
  - While hold_v=1, resp_valid[hold_id]=1 and resp_rdata=hold_data until resp_ready is seen; then hold_v clears.
  - A hold and an inflight never coexist; this is guaranteed by read_ok.
  - Minimum read latency is 1 cycle, with back-to-back throughput of 1 per cycle while resp_ready stays high.
- resp_valid is never asserted for a write.
- At most one bit of resp_valid is high at a time.
- Simultaneous events:
  - A write from port 1 is allowed in the same cycle a held response for port 0 drains.
  - A new read is allowed in the same cycle the hold drains (case c).
- req_ready[i] is 1 only for the granted port. req_ready depends on resp_ready (read_ok) but never on resp_valid of the same cycle's new request.
- Reset mid-operation: any inflight or held response is discarded. No resp_valid appears after resetn deasserts.

Decomposition:
- Shared package (mycpu pkg): SRAM width constants, plus the typedef sram_req_t {we, addr, wdata}, which is also used by the execute-stage bus packing.
- One natural sub-module: rr_arb2, a 2-way round-robin/fixed arbiter holding rr_ptr. The response hold register stays in the top module.

Test Plan:
- Port 0 read of 0x100 with the SRAM returning 0xDEADBEEF, resp_ready=1: en=1 and wen=0 in cycle N; resp_valid=2'b01 and rdata=0xDEADBEEF in N+1; hold_v stays 0.
- Both ports reading every cycle with RR_EN=1: grants alternate 0,1,0,1 starting with port 0 after reset, and each response goes to the correct port.
- RR_EN=0 with both ports requesting for 4 cycles: port 0 is granted all 4 times and port 1 req_ready stays 0.
- Port 1 read with resp_ready[1]=0 for 3 cycles:
  - Data is held, and resp_valid[1] stays high with stable data.
  - A port 0 read is blocked (req_ready[0]=0), while a port 0 write with wen=4'b0011 to 0x200 is granted.
  - When resp_ready[1] rises, the hold drains and the port 0 read is granted in the same cycle.
- resetn pulsed low asynchronously (mid-cycle) while hold_v=1: all outputs go to 0 immediately; after release there is no resp_valid, and the first grant follows rr_ptr=0.
- Back-to-back port 0 reads of 0x0, 0x4 and 0x8 with resp_ready=1: data returns on consecutive cycles in order, with no bubbles.

Source files
------------

// File: rtl/data_sram_arbiter_pkg.sv
// Shared data-SRAM definitions: port widths and the request payload packed by the execute stage.
package data_sram_arbiter_pkg;

  localparam int unsigned SRAM_ADDR_W = 32;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SRAM_BE_W   = SRAM_DATA_W / 8;

  // One SRAM access: all-zero we means read.
  typedef struct packed {
    logic [SRAM_BE_W-1:0]   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/data_sram_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on rr_ptr when RR_EN != 0, else port 0 has fixed priority.
module data_sram_arbiter_rr_arb2 #(
  parameter int unsigned RR_EN = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Pick a winner; after any grant the pointer moves to the other port.
  always_comb begin
    gnt_c    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (req_i == 2'b11) begin
      gnt_c = ((RR_EN != 0) && rr_ptr_q) ? 2'b10 : 2'b01;
    end else begin
      gnt_c = req_i;
    end
    if (gnt_c[0]) begin
      rr_ptr_d = 1'b1;
    end else if (gnt_c[1]) begin
      rr_ptr_d = 1'b0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/data_sram_arbiter.sv
// Shares the data SRAM between the pipeline (port 0) and an auxiliary master (port 1),
// returning 1-cycle read data to the owner with a one-entry hold for backpressure.
module data_sram_arbiter
  import data_sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W,
  parameter int unsigned RR_EN  = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][DATA_W/8-1:0]   req_we,
  input  logic [1:0][ADDR_W-1:0]     req_addr,
  input  logic [1:0][DATA_W-1:0]     req_wdata,
  output logic [1:0]                 resp_valid,
  input  logic [1:0]                 resp_ready,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       data_sram_en,
  output logic [DATA_W/8-1:0]        data_sram_wen,
  output logic [ADDR_W-1:0]          data_sram_addr,
  output logic [DATA_W-1:0]          data_sram_wdata,
  input  logic [DATA_W-1:0]          data_sram_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic              inflight_q, inflight_d;
  logic              inflight_id_q, inflight_id_d;
  logic              hold_v_q, hold_v_d;
  logic              hold_id_q, hold_id_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  logic [1:0] is_wr;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       read_ok;
  logic       sel;
  logic       rd_issue;

  // A read may issue only if next cycle's response slot will be free.
  always_comb begin
    read_ok = 1'b0;
    if (!inflight_q && !hold_v_q) begin
      read_ok = 1'b1;
    end else if (inflight_q && resp_ready[inflight_id_q]) begin
      read_ok = 1'b1;
    end else if (hold_v_q && !inflight_q && resp_ready[hold_id_q]) begin
      read_ok = 1'b1;
    end
  end

  // Writes are always eligible; nothing is eligible while reset is held.
  always_comb begin
    is_wr[0] = |req_we[0];
    is_wr[1] = |req_we[1];
    elig     = req_valid & (is_wr | {2{read_ok}}) & {2{resetn}};
  end

  data_sram_arbiter_rr_arb2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req_i  (elig),
    .gnt_c  (gnt)
  );

  // Drive the SRAM from the winner; all-zero when idle.
  always_comb begin
    req_ready       = gnt;
    sel             = gnt[1];
    data_sram_en    = |gnt;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (data_sram_en) begin
      data_sram_wen   = req_we[sel];
      data_sram_addr  = req_addr[sel];
      data_sram_wdata = req_wdata[sel];
    end
    rd_issue = data_sram_en && !is_wr[sel];
  end

  // Response mux: held data takes the slot, else bypass the SRAM read data.
  always_comb begin
    resp_valid = 2'b00;
    resp_rdata = '0;
    if (hold_v_q) begin
      resp_valid[hold_id_q] = 1'b1;
      resp_rdata            = hold_data_q;
    end else if (inflight_q) begin
      resp_valid[inflight_id_q] = 1'b1;
      resp_rdata                = data_sram_rdata;
    end
  end

  // Next-state for the inflight tracker and the hold register.
  always_comb begin
    inflight_d    = rd_issue;
    inflight_id_d = rd_issue ? sel : inflight_id_q;
    hold_v_d      = hold_v_q;
    hold_id_d     = hold_id_q;
    hold_data_d   = hold_data_q;
    if (hold_v_q && resp_ready[hold_id_q]) begin
      hold_v_d = 1'b0;
    end
    if (inflight_q && !resp_ready[inflight_id_q]) begin
      hold_v_d    = 1'b1;
      hold_id_d   = inflight_id_q;
      hold_data_d = data_sram_rdata;
    end
  end

  // Response-path state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
      hold_v_q      <= 1'b0;
      hold_id_q     <= 1'b0;
      hold_data_q   <= '0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      hold_v_q      <= hold_v_d;
      hold_id_q     <= hold_id_d;
      hold_data_q   <= hold_data_d;
    end
  end

  logic unused_be;
  assign unused_be = ^BE_W;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for async reset and fixed priority.
module tb_data_sram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic               clk;
  logic               resetn;
  logic [1:0]         req_valid;
  logic [1:0][BW-1:0] req_we;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata;
  logic [1:0]         resp_ready;
  logic [DW-1:0]      sram_rdata;

  logic [1:0]    r_req_ready, r_resp_valid;
  logic [DW-1:0] r_resp_rdata, r_wdata;
  logic          r_en;
  logic [BW-1:0] r_wen;
  logic [AW-1:0] r_addr;

  logic [1:0]    f_req_ready, f_resp_valid;
  logic [DW-1:0] f_resp_rdata, f_wdata;
  logic          f_en;
  logic [BW-1:0] f_wen;
  logic [AW-1:0] f_addr;

  data_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) u_rr (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(r_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r_resp_valid), .resp_ready(resp_ready), .resp_rdata(r_resp_rdata),
    .data_sram_en(r_en), .data_sram_wen(r_wen), .data_sram_addr(r_addr),
    .data_sram_wdata(r_wdata), .data_sram_rdata(sram_rdata)
  );

  data_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) u_fp (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(f_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(f_resp_valid), .resp_ready(resp_ready), .resp_rdata(f_resp_rdata),
    .data_sram_en(f_en), .data_sram_wen(f_wen), .data_sram_addr(f_addr),
    .data_sram_wdata(f_wdata), .data_sram_rdata(sram_rdata)
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  valid;
    logic [3:0]  we0;
    logic [3:0]  we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  rready;
    logic [31:0] srd;
    logic [1:0]  e_rdy;
    logic        e_en;
    logic [3:0]  e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(
    input logic rst, input logic [1:0] valid, input logic [3:0] we0, input logic [3:0] we1,
    input logic [31:0] addr0, input logic [31:0] addr1, input logic [31:0] wd0, input logic [31:0] wd1,
    input logic [1:0] rready, input logic [31:0] srd,
    input logic [1:0] e_rdy, input logic e_en, input logic [3:0] e_wen, input logic [31:0] e_addr,
    input logic [31:0] e_wdata, input logic [1:0] e_rv, input logic [31:0] e_rdata);
    vec_t r;
    r.rst = rst; r.valid = valid; r.we0 = we0; r.we1 = we1;
    r.addr0 = addr0; r.addr1 = addr1; r.wd0 = wd0; r.wd1 = wd1;
    r.rready = rready; r.srd = srd;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_wen = e_wen; r.e_addr = e_addr;
    r.e_wdata = e_wdata; r.e_rv = e_rv; r.e_rdata = e_rdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid  = 2'b00;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 2'b00;
    sram_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive(input vec_t t);
    req_valid    = t.valid;
    req_we[0]    = t.we0;
    req_we[1]    = t.we1;
    req_addr[0]  = t.addr0;
    req_addr[1]  = t.addr1;
    req_wdata[0] = t.wd0;
    req_wdata[1] = t.wd1;
    resp_ready   = t.rready;
    sram_rdata   = t.srd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(r_req_ready), 32'h0);
    chk({tag, "_resp_valid"}, 32'(r_resp_valid), 32'h0);
    chk({tag, "_rdata"}, r_resp_rdata, 32'h0);
    chk({tag, "_en"}, 32'(r_en), 32'h0);
    chk({tag, "_wen"}, 32'(r_wen), 32'h0);
    chk({tag, "_addr"}, r_addr, 32'h0);
    chk({tag, "_wdata"}, r_wdata, 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();

    // Single port-0 read with immediate accept.
    vecs[0]  = v(1, 2'b01, 4'h0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 2'b11, 32'h0,        2'b01, 1, 4'h0, 32'h100, 32'h0, 2'b00, 32'h0);
    vecs[1]  = v(0, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0, 32'h0, 32'h0, 2'b11, 32'hDEADBEEF, 2'b00, 0, 4'h0, 32'h0,   32'h0, 2'b01, 32'hDEADBEEF);
    vecs[2]  = v(0, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0, 32'h0, 32'h0, 2'b11, 32'h0,        2'b00, 0, 4'h0, 32'h0,   32'h0, 2'b00, 32'h0);
    // Both ports read every cycle: round-robin alternation.
    vecs[3]  = v(1, 2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h11111111, 32'h22222222, 2'b11, 32'h0,        2'b01, 1, 4'h0, 32'h10, 32'h11111111, 2'b00, 32'h0);
    vecs[4]  = v(0, 2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h11111111, 32'h22222222, 2'b11, 32'hA1A1A1A1, 2'b10, 1, 4'h0, 32'h20, 32'h22222222, 2'b01, 32'hA1A1A1A1);
    vecs[5]  = v(0, 2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h11111111, 32'h22222222, 2'b11, 32'hB2B2B2B2, 2'b01, 1, 4'h0, 32'h10, 32'h11111111, 2'b10, 32'hB2B2B2B2);
    vecs[6]  = v(0, 2'b11, 4'h0, 4'h0, 32'h10, 32'h20, 32'h11111111, 32'h22222222, 2'b11, 32'hC3C3C3C3, 2'b10, 1, 4'h0, 32'h20, 32'h22222222, 2'b01, 32'hC3C3C3C3);
    vecs[7]  = v(0, 2'b00, 4'h0, 4'h0, 32'h0,  32'h0,  32'h0,        32'h0,        2'b11, 32'hD4D4D4D4, 2'b00, 0, 4'h0, 32'h0,  32'h0,        2'b10, 32'hD4D4D4D4);
    // Back-to-back port-0 reads with no bubbles.
    vecs[8]  = v(1, 2'b01, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 32'h0,        2'b01, 1, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0);
    vecs[9]  = v(0, 2'b01, 4'h0, 4'h0, 32'h4, 32'h0, 32'h0, 32'h0, 2'b11, 32'hA0000000, 2'b01, 1, 4'h0, 32'h4, 32'h0, 2'b01, 32'hA0000000);
    vecs[10] = v(0, 2'b01, 4'h0, 4'h0, 32'h8, 32'h0, 32'h0, 32'h0, 2'b11, 32'hA0000004, 2'b01, 1, 4'h0, 32'h8, 32'h0, 2'b01, 32'hA0000004);
    vecs[11] = v(0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 32'hA0000008, 2'b00, 0, 4'h0, 32'h0, 32'h0, 2'b01, 32'hA0000008);
    // Port-1 read held for 3 cycles; port-0 read blocked, port-0 write passes, then read on drain.
    vecs[12] = v(1, 2'b10, 4'h0, 4'h0, 32'h0,   32'h300, 32'h0,        32'h0, 2'b01, 32'h0,        2'b10, 1, 4'h0, 32'h300, 32'h0,        2'b00, 32'h0);
    vecs[13] = v(0, 2'b01, 4'h0, 4'h0, 32'h400, 32'h0,   32'h0,        32'h0, 2'b01, 32'hCAFEF00D, 2'b00, 0, 4'h0, 32'h0,   32'h0,        2'b10, 32'hCAFEF00D);
    vecs[14] = v(0, 2'b01, 4'h0, 4'h0, 32'h400, 32'h0,   32'h0,        32'h0, 2'b01, 32'h12345678, 2'b00, 0, 4'h0, 32'h0,   32'h0,        2'b10, 32'hCAFEF00D);
    vecs[15] = v(0, 2'b01, 4'h3, 4'h0, 32'h200, 32'h0,   32'hAABBCCDD, 32'h0, 2'b01, 32'h87654321, 2'b01, 1, 4'h3, 32'h200, 32'hAABBCCDD, 2'b10, 32'hCAFEF00D);
    vecs[16] = v(0, 2'b01, 4'h0, 4'h0, 32'h400, 32'h0,   32'h0,        32'h0, 2'b11, 32'h55555555, 2'b01, 1, 4'h0, 32'h400, 32'h0,        2'b10, 32'hCAFEF00D);
    vecs[17] = v(0, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0,        32'h0, 2'b11, 32'h0BADC0DE, 2'b00, 0, 4'h0, 32'h0,   32'h0,        2'b01, 32'h0BADC0DE);
    vecs[18] = v(0, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0,        32'h0, 2'b11, 32'h0,        2'b00, 0, 4'h0, 32'h0,   32'h0,        2'b00, 32'h0);
    // Port-0 response held, then port-1 write in the cycle the hold drains.
    vecs[19] = v(0, 2'b01, 4'h0, 4'h0, 32'h600, 32'h0,   32'h0, 32'h0,        2'b10, 32'h0,        2'b01, 1, 4'h0, 32'h600, 32'h0,        2'b00, 32'h0);
    vecs[20] = v(0, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0, 32'h0,        2'b10, 32'h77777777, 2'b00, 0, 4'h0, 32'h0,   32'h0,        2'b01, 32'h77777777);
    vecs[21] = v(0, 2'b10, 4'h0, 4'hF, 32'h0,   32'h700, 32'h0, 32'h99999999, 2'b11, 32'h0,        2'b10, 1, 4'hF, 32'h700, 32'h99999999, 2'b01, 32'h77777777);
    vecs[22] = v(0, 2'b00, 4'h0, 4'h0, 32'h0,   32'h0,   32'h0, 32'h0,        2'b11, 32'h0,        2'b00, 0, 4'h0, 32'h0,   32'h0,        2'b00, 32'h0);

    repeat (2) @(negedge clk);
    #1 chk_all_zero("por");
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(r_req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_en", i), 32'(r_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_wen", i), 32'(r_wen), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d_resp_valid", i), 32'(r_resp_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_en) begin
        chk($sformatf("v%0d_addr", i), r_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), r_wdata, vecs[i].e_wdata);
      end
      if (vecs[i].e_rv != 2'b00) begin
        chk($sformatf("v%0d_rdata", i), r_resp_rdata, vecs[i].e_rdata);
      end
    end

    // Asynchronous reset mid-cycle while a response is held.
    do_reset();
    @(negedge clk);
    req_valid = 2'b10; req_addr[1] = 32'h300; resp_ready = 2'b00;
    #1 chk("ar_grant1", 32'(r_req_ready), 32'h2);
    @(negedge clk);
    req_valid = 2'b00; sram_rdata = 32'hFEEDFACE;
    #1 chk("ar_rv_bypass", 32'(r_resp_valid), 32'h2);
    @(negedge clk);
    req_valid = 2'b01; req_we[0] = 4'hF; req_addr[0] = 32'h500; req_wdata[0] = 32'h5A5A5A5A;
    sram_rdata = 32'h0;
    #1;
    chk("ar_held_rv", 32'(r_resp_valid), 32'h2);
    chk("ar_held_rdata", r_resp_rdata, 32'hFEEDFACE);
    chk("ar_write_en", 32'(r_en), 32'h1);
    #2 resetn = 1'b0;
    #1 chk_all_zero("ar_in_reset");
    @(negedge clk);
    idle_inputs();
    resetn = 1'b1;
    #1 chk("ar_post_rv0", 32'(r_resp_valid), 32'h0);
    @(negedge clk);
    resp_ready = 2'b11;
    #1 chk("ar_post_rv1", 32'(r_resp_valid), 32'h0);
    @(negedge clk);
    req_valid = 2'b11;
    #1 chk("ar_first_grant", 32'(r_req_ready), 32'h1);

    // Fixed priority: port 0 wins every cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 2'b11; req_addr[0] = 32'h40; req_addr[1] = 32'h80; resp_ready = 2'b11;
      sram_rdata = 32'(k);
      #1;
      chk($sformatf("fp%0d_req_ready", k), 32'(f_req_ready), 32'h1);
      chk($sformatf("fp%0d_addr", k), f_addr, 32'h40);
    end
    @(negedge clk);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
